led_matrix_driver: RTL
======================

Name: led_matrix_driver

Overview:
- Drives a 4x4 LED matrix that shows the 16-step sequence. It is the output-direction counterpart to the button matrix scanner.
- Scans one row at a time: asserts that row's select line and sinks the column lines.
- Column pattern comes from the 48-bit beats register (3 bits per beat) and the current beat_count playhead.
- Sits beside audio_controller in top.
- LED index mapping matches the button matrix: index = row*4 + col.

Parameters:
- DWELL_LOG2, default 10: row on-time is 2^DWELL_LOG2 clk cycles; must be >= 3.
- BLANK_CYCLES, default 16: all-off interval before each row, for anti-ghosting; must be >= 1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  scan enable; low parks the matrix dark
- beats  input  48  beat i occupies bits [3i+2:3i]; nonzero means active, and the value is the pitch level 1..7
- beat_count  input  4  current playhead step 0..15
- row_out  output  4  row select, active-high, one-hot or zero
- col_out  output  4  column sink, active-low (0 = LED lit)
- frame_start  output  1  single-cycle pulse when a new frame snapshot is taken

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: row_out=0, col_out=4'hF, frame_start=0, state=BLANK, row index=0, both counters=0, snapshot registers=0.
- Reset asserted mid-row: outputs reach their reset values on the next clk edge.
- State machine, two states:
  - BLANK: row_out=0, col_out=4'hF. Count BLANK_CYCLES cycles, then go to SHOW.
  - SHOW: row_out = one-hot(row index); col_out computed per cycle as below. After 2^DWELL_LOG2 cycles, row index increments mod 4 and the state returns to BLANK.
- Frame snapshot:
  - On the cycle BLANK is entered with row index 0, latch beats and beat_count into snapshot registers and pulse frame_start for that one cycle.
  - This includes the first BLANK after reset release and after enable rises.
  - All display decisions use the snapshot only, so there is no tearing.
  - Input changes become visible at the next frame. Frame period = 4*(BLANK_CYCLES + 2^DWELL_LOG2) cycles.
- Column c of row r in SHOW; beat b = 4r + c; phase = top 3 bits of the dwell counter:
  - active(b): lit for the whole SHOW.
  - inactive and b == snapshot playhead: lit while phase < 2 (25% duty).
  - otherwise: dark.
- Registered outputs: row_out and col_out change together on the same edge, so a row is never selected with a stale column pattern.
- enable low:
  - Next edge forces BLANK with outputs off, row index=0, counters cleared, and no frame_start.
  - When enable rises, the driver starts at row 0 BLANK and takes a fresh snapshot.
  - reset has priority over enable.
- Counter widths:
  - Dwell counter is DWELL_LOG2 bits and wraps naturally.
  - Blank counter is $clog2(BLANK_CYCLES+1) bits.
  - Row index is 2 bits and wraps 3 -> 0.

Optional Feature:
- Macro: LED_PITCH_PWM_EN.
- Defined: an active beat is lit while phase < pitch, where pitch = 1..7 gives 1/8..7/8 duty. The playhead overrides this with full on if that beat is active; an inactive playhead beat keeps the 25% duty rule.
- Undefined: behaviour is binary as specified above; the pitch value is ignored except for the nonzero test.

Decomposition:
- Shared package sequencer_pkg:
  - NUM_BEATS=16, BEAT_BITS=3, MATRIX_DIM=4
  - beat_t typedef (logic[2:0])
  - function beat_field(beats, idx)
  - scan state enum {BLANK, SHOW}
- Also reused by audio_controller and button_matrix_controller.
- Natural sub-module: led_row_pattern. It is combinational: given the snapshot, row index and phase, it returns the 4-bit col_out. This keeps the FSM/counter logic separate from the display rules.

Test Plan (DWELL_LOG2=3, BLANK_CYCLES=2, so frame = 40 cycles):
- Reset then release, beats=0, beat_count=0: frame_start pulses at cycle 1; row 0 SHOW shows col_out=4'b1110 for cycles 0-1 of dwell and 4'hF otherwise; rows 1-3 stay 4'hF; row_out sequence 0001,0010,0100,1000 with 2-cycle zero gaps.
- beats with beat 5 = 3'b001, beat_count=9: row 1 SHOW col_out=4'b1101 for all 8 cycles; row 2 col_out=4'b1101 for phase 0-1 only.
- Change beats mid-frame (during row 2): display is unchanged until the next frame_start, then updated.
- enable dropped during SHOW of row 2: next edge row_out=0, col_out=4'hF. Re-enable: frame_start is asserted one edge later, then row 0 is shown.
- reset pulsed during SHOW: outputs reach reset values on the next edge, and there is no frame_start while reset is high.
- With LED_PITCH_PWM_EN, beat 0 = 3'b100, playhead=15: row 0 col bit0 is low for phases 0-3 and high for phases 4-7; beat 15 (inactive playhead) is lit for phases 0-1.

Source files
------------

// File: rtl/sequencer_pkg.sv
// Shared sequencer types: beat fields, matrix geometry, scan states.
// Reused by the LED driver, audio and button matrix controllers.
package sequencer_pkg;

  localparam int NUM_BEATS  = 16;
  localparam int BEAT_BITS  = 3;
  localparam int MATRIX_DIM = 4;

  typedef logic [BEAT_BITS-1:0] beat_t;

  typedef enum logic {
    BLANK,
    SHOW
  } scan_state_t;

  function automatic beat_t beat_field(
    input logic [NUM_BEATS*BEAT_BITS-1:0] beats,
    input logic [3:0]                     idx
  );
    return beats[BEAT_BITS*idx +: BEAT_BITS];
  endfunction

endpackage

// File: rtl/led_matrix_driver_led_row_pattern.sv
// Column sink pattern for one row from the frame snapshot and dwell phase.
// LED_PITCH_PWM_EN: active beats dim by pitch; otherwise binary on/off.
module led_row_pattern
  import sequencer_pkg::*;
(
  input  logic [47:0] snap_beats,
  input  logic [3:0]  snap_count,
  input  logic [1:0]  row_idx,
  input  logic [2:0]  phase,
  output logic [3:0]  col_out
);

  always_comb begin
    col_out = 4'hF;
    for (int c = 0; c < MATRIX_DIM; c++) begin
      logic [3:0] idx;
      beat_t      f;
      logic       act;
      logic       play;
      logic       lit;
      idx  = {row_idx, 2'(c)};
      f    = beat_field(snap_beats, idx);
      act  = |f;
      play = (idx == snap_count);
      lit  = 1'b0;
`ifdef LED_PITCH_PWM_EN
      if (act)
        lit = play ? 1'b1 : (phase < f);
      else
        lit = play && (phase < 3'd2);
`else
      if (act)
        lit = 1'b1;
      else
        lit = play && (phase < 3'd2);
`endif
      col_out[c] = ~lit;
    end
  end

endmodule

// File: rtl/led_matrix_driver.sv
// 4x4 LED matrix row scanner with blanking and per-frame snapshot.
// Optional LED_PITCH_PWM_EN selects pitch-proportional brightness.
module led_matrix_driver
  import sequencer_pkg::*;
#(
  parameter int DWELL_LOG2   = 10,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [47:0] beats,
  input  logic [3:0]  beat_count,
  output logic [3:0]  row_out,
  output logic [3:0]  col_out,
  output logic        frame_start
);

  localparam int BW = $clog2(BLANK_CYCLES + 1);

  scan_state_t           state, state_nxt;
  logic [1:0]            row_idx, row_nxt;
  logic [DWELL_LOG2-1:0] dwell_cnt, dwell_nxt;
  logic [BW-1:0]         blank_cnt, blank_nxt;
  logic                  armed;
  logic                  snap_take;
  logic [47:0]           snap_beats;
  logic [3:0]            snap_count;
  logic [2:0]            phase_nxt;
  logic [3:0]            pat_col;
  logic [3:0]            row_sel_nxt;
  logic [3:0]            col_nxt;

  // armed: parked after reset/disable; next enabled edge opens a frame
  always_comb begin
    state_nxt = state;
    row_nxt   = row_idx;
    dwell_nxt = dwell_cnt;
    blank_nxt = blank_cnt;
    snap_take = 1'b0;
    if (armed) begin
      state_nxt = BLANK;
      row_nxt   = 2'd0;
      dwell_nxt = '0;
      blank_nxt = '0;
      snap_take = 1'b1;
    end else begin
      unique case (1'b1)
        (state == BLANK): begin
          if (blank_cnt == BW'(BLANK_CYCLES - 1)) begin
            state_nxt = SHOW;
            dwell_nxt = '0;
            blank_nxt = '0;
          end else begin
            blank_nxt = blank_cnt + BW'(1);
          end
        end
        (state == SHOW): begin
          dwell_nxt = dwell_cnt + DWELL_LOG2'(1);
          if (&dwell_cnt) begin
            state_nxt = BLANK;
            row_nxt   = row_idx + 2'd1;
            blank_nxt = '0;
            snap_take = (row_idx == 2'd3);
          end
        end
        default: ;
      endcase
    end
  end

  assign phase_nxt = dwell_nxt[DWELL_LOG2-1 -: 3];

  led_row_pattern u_pat (
    .snap_beats (snap_beats),
    .snap_count (snap_count),
    .row_idx    (row_nxt),
    .phase      (phase_nxt),
    .col_out    (pat_col)
  );

  always_comb begin
    row_sel_nxt = 4'h0;
    col_nxt     = 4'hF;
    if (state_nxt == SHOW) begin
      row_sel_nxt = 4'b0001 << row_nxt;
      col_nxt     = pat_col;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= BLANK;
      row_idx     <= 2'd0;
      dwell_cnt   <= '0;
      blank_cnt   <= '0;
      armed       <= 1'b1;
      snap_beats  <= '0;
      snap_count  <= '0;
      row_out     <= 4'h0;
      col_out     <= 4'hF;
      frame_start <= 1'b0;
    end else if (!enable) begin
      state       <= BLANK;
      row_idx     <= 2'd0;
      dwell_cnt   <= '0;
      blank_cnt   <= '0;
      armed       <= 1'b1;
      row_out     <= 4'h0;
      col_out     <= 4'hF;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      row_idx     <= row_nxt;
      dwell_cnt   <= dwell_nxt;
      blank_cnt   <= blank_nxt;
      armed       <= 1'b0;
      row_out     <= row_sel_nxt;
      col_out     <= col_nxt;
      frame_start <= snap_take;
      if (snap_take) begin
        snap_beats <= beats;
        snap_count <= beat_count;
      end
    end
  end

endmodule
